clk_divider: RTL and testbench
==============================

// Module: clk_divider
// PURPOSE
//   Divides the 50 MHz system clock down to a slow, glitch-free, registered square wave (default 1 Hz).
//   Provides the heartbeat that paces ALU result display and LED refresh logic.
//   Output is a fabric signal for sampling or enable generation, not a global clock tree.
// PARAMETERS
//   CLK_FREQ_HZ  50_000_000  input clock frequency in Hz
//   OUT_FREQ_HZ  1           required output frequency in Hz
//   DIV (localparam)         CLK_FREQ_HZ/OUT_FREQ_HZ (integer division); must be >= 2
//   LOW_CYCLES (localparam)  DIV - DIV/2 (low phase; equals high phase when DIV is even)
//   CNT_W (localparam)       $clog2(DIV), minimum 1
// PORTS
//   Clk      in   1      system clock; all logic on its rising edge
//   Reset    in   1      synchronous, active-low reset (0 = reset, sampled on rising Clk)
//   Clk_out  out  1      divided square wave, registered
//   Tick     out  1      one-cycle pulse on Clk_out rising edge; present only with CLK_DIV_TICK_EN
// BEHAVIOUR
//   - Single clock domain. No asynchronous paths. Reset is sampled only on a rising edge of Clk.
//   - Reset low at a rising edge of Clk: count <= 0, Clk_out <= 0, Tick <= 0 (when present).
//   - Reset has priority over counting, including mid-period.
//   - The phase restarts from count = 0 on the first edge with Reset high.
//   - Counter: count_next = (count == DIV-1) ? 0 : count + 1.
//     - Wraps modulo DIV.
//     - Never exceeds DIV-1.
//     - Unsigned, CNT_W bits.
//   - Output: Clk_out <= (count_next >= LOW_CYCLES).
//     - Clk_out is low for LOW_CYCLES cycles, then high for DIV/2 cycles, then repeats.
//     - Odd DIV: the low phase is one cycle longer than the high phase.
//   - First rising edge of Clk_out:
//     - Occurs LOW_CYCLES rising Clk edges after the first edge with Reset high.
//     - Defaults: 25_000_000 cycles = 500 ms at a 20 ns period.
//   - Period: exactly DIV input cycles. Defaults: 1 s period, 50% duty.
//   - Clk_out changes only directly from a flop. No combinational decode drives the port.
//   - Elaboration check: DIV < 2 or OUT_FREQ_HZ > CLK_FREQ_HZ raises an elaboration error via a generate-time $error.
//   - Non-integer ratios truncate. The resulting frequency is CLK_FREQ_HZ/DIV.
// CONFIGURATION
//   CLK_DIV_TICK_EN defined:
//     - Adds output port Tick.
//     - Tick <= (count_next == LOW_CYCLES): high for exactly one Clk cycle, coincident with the cycle Clk_out first reads 1.
//     - Tick is 0 during reset and at all other times.
//   CLK_DIV_TICK_EN undefined:
//     - No Tick port and no Tick logic.
//     - Clk_out behaviour is identical in both builds.
// TESTING
//   1. CLK_FREQ_HZ=10, OUT_FREQ_HZ=1, Reset=0 for 2 cycles then 1 -> Clk_out=0 during reset.
//      Clk_out rises after 5 edges, falls after 5 more, period 10 cycles.
//   2. CLK_FREQ_HZ=5, OUT_FREQ_HZ=1 (odd DIV) -> Clk_out low 3 cycles, high 2 cycles, period 5, repeating.
//   3. DIV=10, assert Reset=0 while Clk_out=1 (count=7) -> next edge Clk_out=0.
//      After release, the first rise is 5 edges later.
//   4. DIV=2 (CLK_FREQ_HZ=2, OUT_FREQ_HZ=1) -> Clk_out toggles every cycle: 0,1,0,1 after reset.
//   5. Defaults, 20 ns Clk, Reset low 20 ns then high, run 2 s -> Clk_out rises at about 500 ms and 1500 ms.
//      Clk_out falls at about 1000 ms; exactly 2 rising edges in 2 s.
//   6. With CLK_DIV_TICK_EN, DIV=10 -> Tick high exactly one cycle per 10.
//      Tick is coincident with each Clk_out 0->1 transition; it is 0 throughout reset.

Source files
------------

// File: rtl/clk_divider.sv
// Divides Clk by DIV = CLK_FREQ_HZ/OUT_FREQ_HZ into a registered square wave, low phase first.
// Define CLK_DIV_TICK_EN to add the Tick output, a one-cycle pulse on each Clk_out rising edge.
module clk_divider #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int OUT_FREQ_HZ = 1
) (
  input  logic Clk,
  input  logic Reset,
  output logic Clk_out
`ifdef CLK_DIV_TICK_EN
  ,
  output logic Tick
`endif
);

  localparam int DIV        = (OUT_FREQ_HZ > 0) ? (CLK_FREQ_HZ / OUT_FREQ_HZ) : 0;
  localparam int LOW_CYCLES = DIV - DIV / 2;
  localparam int CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(LOW_CYCLES);

  generate
    if (DIV < 2 || OUT_FREQ_HZ > CLK_FREQ_HZ) begin : g_bad_cfg
      $error("clk_divider: CLK_FREQ_HZ/OUT_FREQ_HZ must be at least 2");
    end
  endgenerate

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             clk_out_reg;

  always_comb begin
    count_next = (count_reg == CNT_LAST) ? '0 : count_reg + 1'b1;
  end

  // Output decodes count_next so the registered square wave lines up with the count it represents.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count_reg   <= '0;
      clk_out_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      clk_out_reg <= (count_next >= CNT_RISE);
    end
  end

  assign Clk_out = clk_out_reg;

`ifdef CLK_DIV_TICK_EN
  logic tick_reg;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= (count_next == CNT_RISE);
    end
  end

  assign Tick = tick_reg;
`endif

endmodule

// File: tb/tb_clk_divider.sv
// Randomized-reset bench for clk_divider: four ratios checked every cycle against an
// edges-since-reset arithmetic model, plus literal waveforms for the model itself.
module tb_clk_divider;

  logic clk;
  logic Reset;
  logic outs  [4];
  logic ticks [4];

  int n_vec = 0;
  int n_err = 0;

  // Ratios under test: 10/1, 5/1 (odd), 2/1 (minimum), 23/3 (truncates to 7).
  int divs [4] = '{10, 5, 2, 7};

  int t = 0;             // rising edges with Reset high since the last reset edge
  bit model_valid = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  clk_divider #(.CLK_FREQ_HZ(10), .OUT_FREQ_HZ(1)) u_d10 (
    .Clk(clk), .Reset(Reset), .Clk_out(outs[0])
`ifdef CLK_DIV_TICK_EN
    , .Tick(ticks[0])
`endif
  );
  clk_divider #(.CLK_FREQ_HZ(5), .OUT_FREQ_HZ(1)) u_d5 (
    .Clk(clk), .Reset(Reset), .Clk_out(outs[1])
`ifdef CLK_DIV_TICK_EN
    , .Tick(ticks[1])
`endif
  );
  clk_divider #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) u_d2 (
    .Clk(clk), .Reset(Reset), .Clk_out(outs[2])
`ifdef CLK_DIV_TICK_EN
    , .Tick(ticks[2])
`endif
  );
  clk_divider #(.CLK_FREQ_HZ(23), .OUT_FREQ_HZ(3)) u_d7 (
    .Clk(clk), .Reset(Reset), .Clk_out(outs[3])
`ifdef CLK_DIV_TICK_EN
    , .Tick(ticks[3])
`endif
  );

`ifndef CLK_DIV_TICK_EN
  initial for (int i = 0; i < 4; i++) ticks[i] = 1'b0;
`endif

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", name, got, exp, t, $time);
    end
  endtask

  // Low for div - div/2 cycles, then high for div/2 cycles, phase measured from reset release.
  function automatic int exp_out(input int edges, input int div);
    return ((edges % div) >= (div - div / 2)) ? 1 : 0;
  endfunction

  function automatic int exp_tick(input int edges, input int div);
    return ((edges % div) == (div - div / 2)) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    t           <= Reset ? t + 1 : 0;
    model_valid <= model_valid | !Reset;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("clk_out_div%0d", divs[i]), int'(outs[i]), exp_out(t, divs[i]));
`ifdef CLK_DIV_TICK_EN
        check($sformatf("tick_div%0d", divs[i]), int'(ticks[i]), exp_tick(t, divs[i]));
`endif
      end
    end
  end

  logic [9:0] s10, s5, s2;
  logic [4:0] r10;
  int cycles_left;

  initial begin
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_div10", int'(outs[0]), 0);
    check("reset_out_div5",  int'(outs[1]), 0);
    check("reset_out_div2",  int'(outs[2]), 0);

    Reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      s10[k] = outs[0];
      s5[k]  = outs[1];
      s2[k]  = outs[2];
    end
    check("wave_div10", int'(s10), int'(10'b0111110000));
    check("wave_div5",  int'(s5),  int'(10'b0110001100));
    check("wave_div2",  int'(s2),  int'(10'b0101010101));

    // Land on count 7 of the div-10 instance (high phase), then reset for one edge.
    repeat (7) @(negedge clk);
    check("pre_reset_high_div10", int'(outs[0]), 1);
    Reset = 1'b0;
    @(negedge clk);
    check("mid_period_reset_div10", int'(outs[0]), 0);
    Reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      r10[k] = outs[0];
    end
    check("rise_after_reset_div10", int'(r10), int'(5'b10000));

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        Reset = 1'b0;
        cycles_left = int'($urandom_range(1, 3));
        repeat (cycles_left) @(negedge clk);
        Reset = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
